// File: rtl/instruction_memory_pl.sv
// Instruction store for the 19-bit core: streaming load port, registered fetch port,
// and fault flagging for fetches beyond the most recently loaded program.
module instruction_memory_pl #(
    parameter int                     WORD_SIZE = 19,
    parameter int                     DEPTH     = 1024,
    parameter int                     ADDR_W    = $clog2(DEPTH),
    parameter logic [WORD_SIZE-1:0]   NOP_WORD  = '0
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  LOAD_START,
    input  logic                  LD_VALID,
    input  logic [WORD_SIZE-1:0]  LD_DATA,
    input  logic                  LD_LAST,
    output logic                  LD_READY,
    input  logic                  RD_EN,
    input  logic [ADDR_W-1:0]     RD_ADDR,
    output logic [WORD_SIZE-1:0]  INSTR,
    output logic                  INSTR_VALID,
    output logic                  FETCH_FAULT,
    output logic                  BUSY,
    output logic [ADDR_W:0]       LOADED_WORDS
);

    localparam int                CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LAST_IX = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [WORD_SIZE-1:0]   mem [DEPTH];

    logic                   start;
    logic                   ld_acc;
    logic                   ld_done;
    logic                   rd_acc;
    logic                   rd_hit;

    logic [WORD_SIZE-1:0]   instr_p1;
    logic                   vld_p1;
    logic                   fault_p1;

    // cnt doubles as the write pointer and the loaded-word bound
    assign start   = LOAD_START && (state != S_LOAD);
    assign ld_acc  = LD_VALID && (state == S_LOAD);
    assign ld_done = ld_acc && (LD_LAST || (cnt == LAST_IX));
    assign rd_acc  = RD_EN && (state == S_RUN) && !LOAD_START;
    assign rd_hit  = ({1'b0, RD_ADDR} < cnt);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        LD_READY  = 1'b0;
        BUSY      = 1'b0;
        case (state)
            S_IDLE, S_RUN: begin
                if (LOAD_START) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                LD_READY = 1'b1;
                BUSY     = 1'b1;
                if (ld_done) state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (ld_acc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Array is deliberately unreset; stale words are hidden by the cnt bound
    always_ff @(posedge CLK) begin
        if (ld_acc) begin
            mem[cnt[ADDR_W-1:0]] <= LD_DATA;
        end
    end

    // Fetch result stage
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            instr_p1 <= '0;
            vld_p1   <= 1'b0;
            fault_p1 <= 1'b0;
        end else begin
            vld_p1   <= rd_acc;
            fault_p1 <= rd_acc && !rd_hit;
            if (rd_acc) begin
                instr_p1 <= rd_hit ? mem[RD_ADDR] : NOP_WORD;
            end
        end
    end

    assign INSTR        = instr_p1;
    assign INSTR_VALID  = vld_p1;
    assign FETCH_FAULT  = fault_p1;
    assign LOADED_WORDS = cnt;

endmodule

// File: tb/tb_instruction_memory_pl.sv
// Directed + randomized bench for instruction_memory_pl with a queue-based program model.
module tb_instruction_memory_pl;

    localparam int               WS    = 19;
    localparam int               DEPTH = 12;
    localparam int               AW    = $clog2(DEPTH);
    localparam logic [WS-1:0]    NOP   = 19'h2AAAA;

    logic           CLK;
    logic           RESET_N;
    logic           LOAD_START;
    logic           LD_VALID;
    logic [WS-1:0]  LD_DATA;
    logic           LD_LAST;
    logic           LD_READY;
    logic           RD_EN;
    logic [AW-1:0]  RD_ADDR;
    logic [WS-1:0]  INSTR;
    logic           INSTR_VALID;
    logic           FETCH_FAULT;
    logic           BUSY;
    logic [AW:0]    LOADED_WORDS;

    instruction_memory_pl #(
        .WORD_SIZE (WS),
        .DEPTH     (DEPTH),
        .NOP_WORD  (NOP)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .LOAD_START   (LOAD_START),
        .LD_VALID     (LD_VALID),
        .LD_DATA      (LD_DATA),
        .LD_LAST      (LD_LAST),
        .LD_READY     (LD_READY),
        .RD_EN        (RD_EN),
        .RD_ADDR      (RD_ADDR),
        .INSTR        (INSTR),
        .INSTR_VALID  (INSTR_VALID),
        .FETCH_FAULT  (FETCH_FAULT),
        .BUSY         (BUSY),
        .LOADED_WORDS (LOADED_WORDS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int             errors = 0;
    int             checks = 0;
    logic [WS-1:0]  prog[$];      // words of the current program, index = address
    logic [WS-1:0]  last_instr;   // what INSTR should currently hold
    logic [WS-1:0]  wq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input int addr);
        logic [WS-1:0] e;
        logic          f;
        RD_EN   = 1'b1;
        RD_ADDR = addr[AW-1:0];
        tick();
        f = (addr >= prog.size());
        if (f) e = NOP;
        else   e = prog[addr];
        last_instr = e;
        chk("fetch_instr", INSTR, e);
        chk("fetch_valid", INSTR_VALID, 1);
        chk("fetch_fault", FETCH_FAULT, f);
    endtask

    task automatic idle();
        RD_EN      = 1'b0;
        LD_VALID   = 1'b0;
        LD_LAST    = 1'b0;
        LOAD_START = 1'b0;
        tick();
        chk("idle_valid", INSTR_VALID, 0);
        chk("idle_fault", FETCH_FAULT, 0);
        chk("idle_instr_hold", INSTR, last_instr);
    endtask

    // Caller may leave RD_EN high to exercise a fetch colliding with LOAD_START.
    task automatic load(input logic [WS-1:0] w[$], input bit use_last, input bit restart_mid);
        int n;
        n = w.size();
        LOAD_START = 1'b1;
        tick();
        LOAD_START = 1'b0;
        RD_EN      = 1'b0;
        chk("start_busy", BUSY, 1);
        chk("start_ready", LD_READY, 1);
        chk("start_loaded", LOADED_WORDS, 0);
        chk("start_drop_valid", INSTR_VALID, 0);
        chk("start_instr_hold", INSTR, last_instr);
        prog.delete();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                LD_VALID = 1'b0;
                tick();
                chk("gap_loaded", LOADED_WORDS, i);
                chk("gap_busy", BUSY, 1);
            end
            LD_VALID   = 1'b1;
            LD_DATA    = w[i];
            LD_LAST    = use_last && (i == n - 1);
            LOAD_START = restart_mid && (i == 1);
            tick();
            prog.push_back(w[i]);
            if (i < n - 1) begin
                chk("load_loaded", LOADED_WORDS, i + 1);
                chk("load_ready", LD_READY, 1);
            end
        end
        LD_VALID   = 1'b0;
        LD_LAST    = 1'b0;
        LOAD_START = 1'b0;
        chk("done_busy", BUSY, 0);
        chk("done_ready", LD_READY, 0);
        chk("done_loaded", LOADED_WORDS, n);
    endtask

    initial begin
        RESET_N    = 1'b0;
        LOAD_START = 1'b0;
        LD_VALID   = 1'b0;
        LD_DATA    = '0;
        LD_LAST    = 1'b0;
        RD_EN      = 1'b0;
        RD_ADDR    = '0;
        last_instr = '0;
        tick();
        tick();
        chk("rst_instr", INSTR, 0);
        chk("rst_valid", INSTR_VALID, 0);
        chk("rst_fault", FETCH_FAULT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_ready", LD_READY, 0);
        chk("rst_loaded", LOADED_WORDS, 0);
        RESET_N = 1'b1;
        tick();

        // Fetch with no program loaded is refused
        RD_EN   = 1'b1;
        RD_ADDR = '0;
        tick();
        chk("idle_fetch_valid", INSTR_VALID, 0);
        chk("idle_fetch_busy", BUSY, 0);
        chk("idle_fetch_loaded", LOADED_WORDS, 0);
        chk("idle_fetch_instr", INSTR, 0);
        RD_EN = 1'b0;

        // Three-word program, then back-to-back fetches
        wq = '{19'h00001, 19'h00002, 19'h7FFFF};
        load(wq, 1'b1, 1'b0);
        fetch(0);
        fetch(1);
        fetch(2);
        fetch(3);
        idle();

        // Full-depth load without LD_LAST
        wq.delete();
        for (int i = 0; i < DEPTH; i++) wq.push_back(WS'($urandom));
        load(wq, 1'b0, 1'b0);
        LD_VALID = 1'b1;
        LD_DATA  = 19'h55555;
        tick();
        chk("full_ready_low", LD_READY, 0);
        chk("full_loaded_hold", LOADED_WORDS, DEPTH);
        LD_VALID = 1'b0;
        fetch(DEPTH - 1);
        fetch(0);
        for (int i = 0; i < 10; i++) fetch(int'($urandom_range(0, (1 << AW) - 1)));
        idle();

        // Reload from RUN with a colliding fetch, then one-word program
        RD_EN   = 1'b1;
        RD_ADDR = '0;
        wq = '{19'h12345};
        load(wq, 1'b1, 1'b0);
        fetch(0);
        fetch(1);
        idle();

        // Random-length program with an ignored LOAD_START in mid-stream
        wq.delete();
        for (int i = 0; i < int'($urandom_range(3, DEPTH - 1)); i++) wq.push_back(WS'($urandom));
        load(wq, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) fetch(int'($urandom_range(0, (1 << AW) - 1)));
        idle();

        // Reset during a load aborts it
        LOAD_START = 1'b1;
        tick();
        LOAD_START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            LD_VALID = 1'b1;
            LD_DATA  = WS'($urandom);
            tick();
        end
        chk("abort_pre_loaded", LOADED_WORDS, 2);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("abort_instr", INSTR, 0);
        chk("abort_valid", INSTR_VALID, 0);
        chk("abort_fault", FETCH_FAULT, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_ready", LD_READY, 0);
        chk("abort_loaded", LOADED_WORDS, 0);
        tick();
        RESET_N = 1'b1;
        prog.delete();
        last_instr = '0;
        tick();
        tick();
        chk("post_ready", LD_READY, 0);
        chk("post_loaded", LOADED_WORDS, 0);
        chk("post_busy", BUSY, 0);
        LD_VALID = 1'b0;
        RD_EN    = 1'b1;
        RD_ADDR  = '0;
        tick();
        chk("post_fetch_valid", INSTR_VALID, 0);
        RD_EN = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
